// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared offsets, ctrl layout and reset constants for the machine timer
package timer_pkg;

  // Word offsets within the timer window
  localparam logic [4:0] TMR_MTIME_LO    = 5'h00;
  localparam logic [4:0] TMR_MTIME_HI    = 5'h04;
  localparam logic [4:0] TMR_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] TMR_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] TMR_CTRL        = 5'h10;

  // ctrl bit positions
  localparam int CTRL_CNT_EN_BIT = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_DIV_LSB    = 8;
  localparam int TMR_DIV_W       = 8;

  // mtimecmp comes out of reset at all-ones so no interrupt is pending
  localparam logic [63:0] TMR_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [TMR_DIV_W-1:0] div;
    logic                 cnt_en;
    logic                 irq_en;
  } ctrl_t;

  // Software-visible image of ctrl
  function automatic logic [31:0] ctrl_to_word(ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_CNT_EN_BIT] = c.cnt_en;
    w[CTRL_IRQ_EN_BIT] = c.irq_en;
    w[CTRL_DIV_LSB +: TMR_DIV_W] = c.div;
    return w;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - programmable divider producing mtime increment ticks
module timer_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // A tick fires on the last count of each period; div=0 ticks every cycle
  assign tick_o = en_i && (cnt_q == div_i);

  // Next count: clear wins, otherwise wrap on tick or advance while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_irq_unit.sv
// rtl/timer_irq_unit.sv - memory-mapped mtime/mtimecmp timer with machine timer interrupt
module timer_irq_unit
  import timer_pkg::*;
#(
  parameter int          DIV_W        = 8,
  parameter logic [63:0] MTIMECMP_RST = TMR_MTIMECMP_RST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic        re,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        timer_irq
);

  logic [31:0] mtime_lo_q, mtime_lo_d;
  logic [31:0] mtime_hi_q, mtime_hi_d;
  logic [31:0] cmp_lo_q, cmp_lo_d;
  logic [31:0] cmp_hi_q, cmp_hi_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic [31:0] rdata_q, rdata_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic        rvalid_q, rvalid_d;
  logic        irq_q, irq_d;

  logic [4:0]  word;
  logic        wr, rd, tick, cmp_hit;
  logic [63:0] mtime, mtime_inc, mtimecmp;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign word      = {addr[4:2], 2'b00};
  assign wr        = sel & we;
  assign rd        = sel & re;
  assign mtime     = {mtime_hi_q, mtime_lo_q};
  assign mtime_inc = mtime + 64'd1;
  assign mtimecmp  = {cmp_hi_q, cmp_lo_q};
  assign cmp_hit   = (mtime >= mtimecmp);
  assign unused_bits = ^{addr[1:0], wdata[31:16], wdata[7:2]};

  timer_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en_i   (ctrl_q.cnt_en),
    .clr_i  (wr && (word == TMR_CTRL)),
    .div_i  (DIV_W'(ctrl_q.div)),
    .tick_o (tick)
  );

  // Read mux over current (pre-write) register values
  always_comb begin
    rd_val = '0;
    case (word)
      TMR_MTIME_LO:    rd_val = mtime_lo_q;
      TMR_MTIME_HI:    rd_val = hi_shadow_q;
      TMR_MTIMECMP_LO: rd_val = cmp_lo_q;
      TMR_MTIMECMP_HI: rd_val = cmp_hi_q;
      TMR_CTRL:        rd_val = ctrl_to_word(ctrl_q);
      default:         rd_val = '0;
    endcase
  end

  // Register-file next state: software writes beat the tick for mtime
  always_comb begin
    mtime_lo_d  = mtime_lo_q;
    mtime_hi_d  = mtime_hi_q;
    cmp_lo_d    = cmp_lo_q;
    cmp_hi_d    = cmp_hi_q;
    ctrl_d      = ctrl_q;
    hi_shadow_d = hi_shadow_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    irq_d       = ctrl_q.irq_en & cmp_hit;

    if (wr && (word == TMR_MTIME_LO)) begin
      mtime_lo_d = wdata;
    end else if (wr && (word == TMR_MTIME_HI)) begin
      mtime_hi_d = wdata;
    end else if (tick) begin
      {mtime_hi_d, mtime_lo_d} = mtime_inc;
    end

    if (wr && (word == TMR_MTIMECMP_LO)) cmp_lo_d = wdata;
    if (wr && (word == TMR_MTIMECMP_HI)) cmp_hi_d = wdata;
    if (wr && (word == TMR_CTRL)) begin
      ctrl_d.div    = wdata[CTRL_DIV_LSB +: TMR_DIV_W];
      ctrl_d.cnt_en = wdata[CTRL_CNT_EN_BIT];
      ctrl_d.irq_en = wdata[CTRL_IRQ_EN_BIT];
    end

    if (rd) begin
      rdata_d  = rd_val;
      rvalid_d = 1'b1;
      // Reading lo freezes hi so a lo-then-hi pair is a coherent 64-bit sample
      if (word == TMR_MTIME_LO) hi_shadow_d = mtime_hi_q;
    end
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_lo_q  <= '0;
      mtime_hi_q  <= '0;
      cmp_lo_q    <= MTIMECMP_RST[31:0];
      cmp_hi_q    <= MTIMECMP_RST[63:32];
      ctrl_q      <= '0;
      hi_shadow_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      mtime_lo_q  <= mtime_lo_d;
      mtime_hi_q  <= mtime_hi_d;
      cmp_lo_q    <= cmp_lo_d;
      cmp_hi_q    <= cmp_hi_d;
      ctrl_q      <= ctrl_d;
      hi_shadow_q <= hi_shadow_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      irq_q       <= irq_d;
    end
  end

  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign timer_irq = irq_q;

endmodule

// File: tb/tb_timer_irq_unit.sv
// tb/tb_timer_irq_unit.sv - scoreboard bench for timer_irq_unit
module tb_timer_irq_unit;

  logic        clk;
  logic        rst;
  logic        sel, we, re;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        timer_irq;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];

  timer_irq_unit dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .we        (we),
    .re        (re),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // All access tasks are entered on a falling edge and return on the next one
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; re = 1'b0; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input string n, input logic [4:0] a, input logic [31:0] e);
    exp_t x;
    x.name = n; x.val = e;
    exp_q.push_back(x);
    sel = 1'b1; we = 1'b0; re = 1'b1; addr = a;
    @(negedge clk);
    sel = 1'b0; re = 1'b0;
  endtask

  task automatic rdwr(input string n, input logic [4:0] a, input logic [31:0] d, input logic [31:0] e);
    exp_t x;
    x.name = n; x.val = e;
    exp_q.push_back(x);
    sel = 1'b1; we = 1'b1; re = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; re = 1'b0;
  endtask

  // Monitor: every rvalid must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rdata %h with no read outstanding", rdata);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk(x.name, rdata, x.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sel = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst_irq", {31'b0, timer_irq}, 32'h0);
    rd("rst_cmp_lo", 5'h08, 32'hFFFF_FFFF);
    rd("rst_cmp_hi", 5'h0C, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("rvalid_one_cycle", {31'b0, rvalid}, 32'h0);

    // div=3: one tick every 4 cycles, 10 ticks in 40 cycles
    wr(5'h10, 32'h0000_0301);
    repeat (40) @(negedge clk);
    wr(5'h10, 32'h0000_0000);
    rd("count_div3", 5'h00, 32'd10);
    repeat (5) @(negedge clk);
    rd("count_frozen", 5'h00, 32'd10);
    rd("ctrl_readback", 5'h10, 32'h0000_0000);

    // Carry from lo into hi over two ticks
    wr(5'h04, 32'h0);
    wr(5'h00, 32'hFFFF_FFFE);
    wr(5'h10, 32'h0000_0001);
    @(negedge clk);
    wr(5'h10, 32'h0000_0000);
    rd("carry_lo", 5'h00, 32'h0);
    rd("carry_hi", 5'h04, 32'h1);

    // Lo read just before a carry; hi read after it returns the shadow
    wr(5'h04, 32'h0);
    wr(5'h00, 32'hFFFF_FFFF);
    wr(5'h10, 32'h0000_0001);
    rd("atomic_lo", 5'h00, 32'hFFFF_FFFF);
    rd("atomic_hi_shadow", 5'h04, 32'h0);
    wr(5'h10, 32'h0000_0000);
    rd("after_carry_lo", 5'h00, 32'h2);
    rd("after_carry_hi", 5'h04, 32'h1);

    // Compare and interrupt timing
    wr(5'h0C, 32'h0);
    wr(5'h08, 32'h20);
    wr(5'h04, 32'h0);
    wr(5'h00, 32'h1E);
    wr(5'h10, 32'h0000_0003);
    chk("irq_low_1e", {31'b0, timer_irq}, 32'h0);
    @(negedge clk);
    chk("irq_low_1f", {31'b0, timer_irq}, 32'h0);
    @(negedge clk);
    chk("irq_low_at_20", {31'b0, timer_irq}, 32'h0);
    @(negedge clk);
    chk("irq_rise", {31'b0, timer_irq}, 32'h1);
    wr(5'h08, 32'h100);
    chk("irq_hold_on_cmp_write", {31'b0, timer_irq}, 32'h1);
    @(negedge clk);
    chk("irq_drop", {31'b0, timer_irq}, 32'h0);

    // Write to mtime_lo coincident with a tick: write wins, no increment
    wr(5'h10, 32'h0000_0001);
    wr(5'h00, 32'h55);
    wr(5'h10, 32'h0000_0000);
    rd("tick_write_lo", 5'h00, 32'h56);
    rd("tick_write_hi", 5'h04, 32'h0);

    // Simultaneous store and load: old value out, new value stored
    rdwr("rdwr_old", 5'h08, 32'h77, 32'h100);
    rd("rdwr_new", 5'h08, 32'h77);

    // Unmapped offset
    wr(5'h14, 32'hDEAD_BEEF);
    rd("unmapped", 5'h14, 32'h0);

    // Asynchronous reset with interrupt asserted
    wr(5'h00, 32'h100);
    wr(5'h10, 32'h0000_0003);
    @(negedge clk);
    chk("irq_before_rst", {31'b0, timer_irq}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("irq_async_clear", {31'b0, timer_irq}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("irq_after_rst", {31'b0, timer_irq}, 32'h0);
    rd("rst_mtime_lo", 5'h00, 32'h0);
    rd("rst_ctrl", 5'h10, 32'h0);
    rd("rst_cmp_lo2", 5'h08, 32'hFFFF_FFFF);
    rd("unmapped_after_rst", 5'h14, 32'h0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
